scsa_seq_ctrl: RTL
==================

SCSA_SEQ_CTRL -- requirements
Module: scsa_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; must be a multiple of 4.
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  controller can accept operands.
REQ-006 SHALL have port A_i  input  WIDTH  operand A.
REQ-007 SHALL have port B_i  input  WIDTH  operand B.
REQ-008 SHALL have port Cin_i  input  1  carry-in to slice 0.
REQ-009 SHALL have port approx_en  input  1  selects the speculative carry chain; sampled with the operands.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port S_o  output  WIDTH  sum.
REQ-013 SHALL have port Co_o  output  1  carry-out of the top slice.
REQ-014 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-015 SHALL time-share one 4-bit sum block (S_i, Co_i, A_i, B_i, Co_iprev) across NSLICE = WIDTH/4 slices, LSB slice first.
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE, with IDLE the reset state.
REQ-017 IDLE: SHALL drive in_ready=1, and on in_valid SHALL latch A_i, B_i, approx_en, set carry_reg=Cin_i and slice counter=0, then go to RUN.
REQ-018 RUN: SHALL present slice k (bits 4k+3:4k) of the latched operands plus carry_reg to the sum block each cycle, write S_i into the S_o slice k, and increment k.
REQ-019 Exact mode: SHALL load carry_reg with the sum block Co_i after each slice.
REQ-020 Approx mode: SHALL feed slice k≥1 with the speculated carry A[4k-1]&B[4k-1] from the latched operands, ignoring the true Co_i; slice 0 SHALL still use Cin_i.
REQ-021 On the last slice SHALL capture Co_o as the true Co_i of that slice in both modes, then go to DONE.
REQ-022 Latency: SHALL assert out_valid after NSLICE rising edges following the accepting edge (4 edges for WIDTH=16).
REQ-023 DONE: SHALL hold out_valid=1 with S_o and Co_o stable until out_ready=1, then return to IDLE on that edge.
REQ-024 SHALL keep in_ready=0 in RUN and DONE, so no operands are accepted while busy; minimum issue interval is NSLICE+2 cycles.
REQ-025 SHALL ignore in_valid and input changes outside IDLE, and SHALL ignore out_ready outside DONE.
REQ-026 SHALL perform all arithmetic modulo 2^WIDTH, with overflow reported only on Co_o.

Reset
REQ-027 When rst=1 at a clock edge, SHALL enter IDLE with S_o=0, Co_o=0, out_valid=0, busy=0, carry_reg=0 and counter=0; in_ready SHALL be 1 after reset is released.
REQ-028 Reset asserted in RUN or DONE SHALL abort the operation and discard the partial result, with no out_valid pulse.

Structure
REQ-029 SHALL place SLICE_W=4, the state encoding and the NSLICE derivation in a shared package, scsa_pkg.
REQ-030 SHALL instantiate the existing sum_block exactly once as its sole sub-module; the FSM, operand registers, slice mux and result register SHALL live in scsa_seq_ctrl.

Verification
REQ-031 SHALL cover exact mode: A=0x00FF, B=0x0001, Cin=0 -> S_o=0x0100, Co_o=0, out_valid 4 edges after accept.
REQ-032 SHALL cover approx mode: A=0x00FF, B=0x0001, Cin=0 -> S_o=0x00F0, Co_o=0 (speculated carries both 0).
REQ-033 SHALL cover overflow and carry-in: 0xFFFF+0x0001, Cin=0 -> S_o=0x0000, Co_o=1; and 0x1234+0x4321, Cin=1 -> S_o=0x5556, Co_o=0.
REQ-034 SHALL cover backpressure: out_ready held 0 for 3 cycles in DONE -> S_o/out_valid stable, in_ready=0, in_valid pulses ignored; result accepted on the first out_ready=1 edge, then IDLE.
REQ-035 SHALL cover reset mid-operation: rst for 1 cycle at RUN slice 2 -> IDLE, S_o=0, out_valid never asserted; the next request 0x0001+0x0001 -> 0x0002.

Source files
------------

// File: rtl/scsa_pkg.sv
// Shared definitions for the sequential slice adder controller: slice width,
// FSM encoding and helpers to derive slice count and counter width.
package scsa_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sum_block.sv
// Four-bit sum block: adds two nibbles and an incoming carry, producing the
// nibble sum and its carry-out.
module sum_block
  import scsa_pkg::*;
(
  input  logic [SLICE_W-1:0] A_i,
  input  logic [SLICE_W-1:0] B_i,
  input  logic               Co_iprev,
  output logic [SLICE_W-1:0] S_i,
  output logic               Co_i
);

  logic [SLICE_W:0] sum_full;

  always_comb begin
    sum_full = {1'b0, A_i} + {1'b0, B_i} + {{SLICE_W{1'b0}}, Co_iprev};
    S_i      = sum_full[SLICE_W-1:0];
    Co_i     = sum_full[SLICE_W];
  end

endmodule

// File: rtl/scsa_seq_ctrl.sv
// Sequential controller that time-shares one 4-bit sum block over WIDTH/4
// slices, LSB first, with an optional speculative (approximate) carry chain.
module scsa_seq_ctrl
  import scsa_pkg::*;
#(
  parameter int WIDTH = 16  // must be a multiple of SLICE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             Cin_i,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S_o,
  output logic             Co_o,
  output logic             busy
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int CNT_W  = cnt_width(NSLICE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             approx_q, approx_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SLICE_W-1:0] a_slices [NSLICE];
  logic [SLICE_W-1:0] b_slices [NSLICE];
  logic [SLICE_W-1:0] a_sl, b_sl, sum_s;
  logic               sum_co;

  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
    assign a_slices[gi] = a_q[gi*SLICE_W +: SLICE_W];
    assign b_slices[gi] = b_q[gi*SLICE_W +: SLICE_W];
  end

  assign a_sl = a_slices[cnt_q];
  assign b_sl = b_slices[cnt_q];

  sum_block u_sum_block (
    .A_i      (a_sl),
    .B_i      (b_sl),
    .Co_iprev (carry_q),
    .S_i      (sum_s),
    .Co_i     (sum_co)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    approx_d = approx_q;
    carry_d  = carry_q;
    co_d     = co_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = A_i;
          b_d      = B_i;
          approx_d = approx_en;
          carry_d  = Cin_i;
          cnt_d    = '0;
          s_d      = '0;
          co_d     = 1'b0;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (cnt_q == CNT_W'(i)) s_d[i*SLICE_W +: SLICE_W] = sum_s;
        end
        // The speculated carry into slice k+1 is A&B of the top bit of slice k.
        carry_d = approx_q ? (a_sl[SLICE_W-1] & b_sl[SLICE_W-1]) : sum_co;
        if (cnt_q == LAST_CNT) begin
          co_d    = sum_co;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      approx_q <= 1'b0;
      carry_q  <= 1'b0;
      co_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      approx_q <= approx_d;
      carry_q  <= carry_d;
      co_q     <= co_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign S_o       = s_q;
  assign Co_o      = co_q;

endmodule
